// File: rtl/ftdi_byte_fifo_if.sv
// ftdi_byte_fifo_if
//   Bundles the handshake, data and status signals of one ftdi_byte_fifo.
//   The master modport belongs to the logic that pushes and pops bytes
//   (the FT2232H bridge side or the DMM side). The slave modport belongs
//   to the FIFO itself.
//
//   Handshake semantics:
//     A write is taken on a rising edge when iWrEn=1 and oFull=0.
//     A read is taken on a rising edge when iRdEn=1 and oEmpty=0.
//     Requests made while full or empty are dropped and have no side effect,
//     apart from the optional sticky error flags.
//     oRdData changes only on the edge that takes a read, and then holds.
//
//   Signals:
//     iWrEn, iWrData        write request and data
//     iRdEn                 read request
//     iClrErr               clears the sticky error flags
//     oFull, oEmpty         occupancy limits
//     oCount                occupancy, 0..2**ADDR_W
//     oAlmostFull/Empty     threshold flags
//     oRdData               read data, one-cycle latency
//     oOverflow/oUnderflow  sticky error flags
interface ftdi_byte_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              iWrEn;
  logic [DATA_W-1:0] iWrData;
  logic              oFull;
  logic              iRdEn;
  logic [DATA_W-1:0] oRdData;
  logic              oEmpty;
  logic [ADDR_W:0]   oCount;
  logic              oAlmostFull;
  logic              oAlmostEmpty;
  logic              iClrErr;
  logic              oOverflow;
  logic              oUnderflow;

  modport master (
    output iWrEn, iWrData, iRdEn, iClrErr,
    input  oFull, oRdData, oEmpty, oCount, oAlmostFull, oAlmostEmpty,
           oOverflow, oUnderflow
  );

  modport slave (
    input  iWrEn, iWrData, iRdEn, iClrErr,
    output oFull, oRdData, oEmpty, oCount, oAlmostFull, oAlmostEmpty,
           oOverflow, oUnderflow
  );
endinterface

// File: rtl/ftdi_byte_fifo.sv
// ftdi_byte_fifo
//   Single-clock byte FIFO that sits between the FT2232H async bridge and the
//   DMM logic. Read data has one-cycle latency: the byte is registered on the
//   edge that takes the read, so it is available in the next cycle.
//
//   Ports:
//     iClk  sole clock, rising edge
//     iRst  synchronous active-high reset. It has priority over every request.
//     bus   ftdi_byte_fifo_if.slave. See the interface file for the handshake.
//
//   Optional feature:
//     BYTE_FIFO_ERR_FLAGS_EN  When defined, this build has the sticky
//                             oOverflow and oUnderflow flags, which iClrErr
//                             clears. When undefined, both flags are tied to
//                             0 and iClrErr is ignored.
module ftdi_byte_fifo #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input logic                iClk,
  input logic                iRst,
  ftdi_byte_fifo_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AFULL  = (ADDR_W+1)'(AFULL_LEVEL);
  localparam logic [ADDR_W:0] AEMPTY = (ADDR_W+1)'(AEMPTY_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  // The pointers carry one extra wrap bit. This bit tells full apart from
  // empty when the low address bits of the two pointers are equal.
  logic [ADDR_W:0] wp, rp;
  logic [ADDR_W:0] wpNext, rpNext, cntNext;
  logic            wrAcc, rdAcc, fullNext, emptyNext;

  // Acceptance uses the registered flags, so the flags describe the state at
  // the start of the cycle. The status outputs are computed from the next
  // pointers, so they already show the state after the edge.
  always_comb begin
    wrAcc     = bus.iWrEn & ~bus.oFull;
    rdAcc     = bus.iRdEn & ~bus.oEmpty;
    wpNext    = wrAcc ? wp + 1'b1 : wp;
    rpNext    = rdAcc ? rp + 1'b1 : rp;
    cntNext   = wpNext - rpNext;
    emptyNext = (wpNext == rpNext);
    fullNext  = (wpNext[ADDR_W-1:0] == rpNext[ADDR_W-1:0]) &&
                (wpNext[ADDR_W] != rpNext[ADDR_W]);
  end

  // The memory has no reset. A write request in a reset cycle is blocked, so
  // reset keeps its priority.
  always_ff @(posedge iClk) begin
    if (!iRst && wrAcc) mem[wp[ADDR_W-1:0]] <= bus.iWrData;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wp               <= '0;
      rp               <= '0;
      bus.oRdData      <= '0;
      bus.oEmpty       <= 1'b1;
      bus.oFull        <= 1'b0;
      bus.oCount       <= '0;
      bus.oAlmostFull  <= 1'b0;
      bus.oAlmostEmpty <= 1'b1;
    end else begin
      wp               <= wpNext;
      rp               <= rpNext;
      if (rdAcc) bus.oRdData <= mem[rp[ADDR_W-1:0]];
      bus.oEmpty       <= emptyNext;
      bus.oFull        <= fullNext;
      bus.oCount       <= cntNext;
      bus.oAlmostFull  <= (cntNext >= AFULL);
      bus.oAlmostEmpty <= (cntNext <= AEMPTY);
    end
  end

`ifdef BYTE_FIFO_ERR_FLAGS_EN
  // When a set and a clear happen in the same cycle, the set wins.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      bus.oOverflow  <= 1'b0;
      bus.oUnderflow <= 1'b0;
    end else begin
      bus.oOverflow  <= (bus.iWrEn & bus.oFull) |
                        (bus.oOverflow & ~bus.iClrErr);
      bus.oUnderflow <= (bus.iRdEn & bus.oEmpty) |
                        (bus.oUnderflow & ~bus.iClrErr);
    end
  end
`else
  logic unusedClrErr;
  assign unusedClrErr   = bus.iClrErr;
  assign bus.oOverflow  = 1'b0;
  assign bus.oUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_ftdi_byte_fifo.sv
// tb_ftdi_byte_fifo
//   Self-checking bench for ftdi_byte_fifo. A queue model tracks the stored
//   bytes, the last byte read and the sticky error flags. A compare process
//   checks every DUT output against this model on each falling edge. Directed
//   scenarios add hand-computed literal expectations. A randomized phase
//   follows them.
module tb_ftdi_byte_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

`ifdef BYTE_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftdi_byte_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ftdi_byte_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int nChecks = 0;
  int nFail   = 0;
  logic checkOn = 1'b0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mRd;
  logic              mOvf, mUnf;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model updates from the inputs seen at the rising edge. The inputs
  // change only at #1 after each edge, so they are stable here.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mRd  = '0;
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      automatic bit wasFull  = (exp_q.size() == DEPTH);
      automatic bit wasEmpty = (exp_q.size() == 0);
      if (ERR_EN) begin
        if (bus.iClrErr) begin mOvf = 1'b0; mUnf = 1'b0; end
        if (bus.iWrEn && wasFull)  mOvf = 1'b1;
        if (bus.iRdEn && wasEmpty) mUnf = 1'b1;
      end
      if (bus.iRdEn && !wasEmpty) mRd = exp_q.pop_front();
      if (bus.iWrEn && !wasFull)  exp_q.push_back(bus.iWrData);
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      chk("count",   32'(bus.oCount),       32'(exp_q.size()));
      chk("empty",   32'(bus.oEmpty),       32'(exp_q.size() == 0));
      chk("full",    32'(bus.oFull),        32'(exp_q.size() == DEPTH));
      chk("afull",   32'(bus.oAlmostFull),  32'(exp_q.size() >= 12));
      chk("aempty",  32'(bus.oAlmostEmpty), 32'(exp_q.size() <= 2));
      chk("rddata",  32'(bus.oRdData),      32'(mRd));
      chk("ovf",     32'(bus.oOverflow),    32'(mOvf));
      chk("unf",     32'(bus.oUnderflow),   32'(mUnf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                      input logic clr);
    bus.iWrEn   = wr;
    bus.iWrData = d;
    bus.iRdEn   = rd;
    bus.iClrErr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOn = 1'b1;

    // Reset state.
    chk("rst_empty",  32'(bus.oEmpty),       32'd1);
    chk("rst_full",   32'(bus.oFull),        32'd0);
    chk("rst_count",  32'(bus.oCount),       32'd0);
    chk("rst_rddata", 32'(bus.oRdData),      32'h00);
    chk("rst_aempty", 32'(bus.oAlmostEmpty), 32'd1);
    chk("rst_ovf",    32'(bus.oOverflow),    32'd0);

    // Single byte.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("single_notempty", 32'(bus.oEmpty), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_rd",    32'(bus.oRdData), 32'hAA);
    chk("single_empty", 32'(bus.oEmpty),  32'd1);

    // Fill, overflow, then drain.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_afull", 32'(bus.oAlmostFull), 32'(i + 1 >= 12));
    end
    chk("fill_count", 32'(bus.oCount), 32'd16);
    chk("fill_full",  32'(bus.oFull),  32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_count", 32'(bus.oCount),    32'd16);
    chk("ovf_flag",  32'(bus.oOverflow), 32'(ERR_EN));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(bus.oRdData), 32'(i));
      if (i == 0) chk("drain_notfull", 32'(bus.oFull), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.oOverflow), 32'd0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_data", 32'(bus.oRdData), 32'h20 + 32'(i));
    end
    chk("wrap_count", 32'(bus.oCount), 32'd0);

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h45 + 8'(i), 1'b1, 1'b0);
      chk("both_data",  32'(bus.oRdData), 32'h40 + 32'(i));
      chk("both_count", 32'(bus.oCount),  32'd5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("both_last", 32'(bus.oRdData), 32'h4C);

    // Simultaneous read and write when empty.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("emptyboth_count", 32'(bus.oCount),  32'd1);
    chk("emptyboth_rd",    32'(bus.oRdData), 32'h4C);

    // Simultaneous read and write when full.
    for (int i = 0; i < 15; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    chk("full_pre", 32'(bus.oFull), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fullboth_count", 32'(bus.oCount),  32'd15);
    chk("fullboth_rd",    32'(bus.oRdData), 32'h55);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullboth_last", 32'(bus.oRdData), 32'h6E);

    // Reset mid-stream.
    for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    chk("mid_count7", 32'(bus.oCount), 32'd7);
    rst = 1'b1;
    step(1'b1, 8'h99, 1'b1, 1'b1);
    rst = 1'b0;
    chk("mid_empty",  32'(bus.oEmpty),  32'd1);
    chk("mid_count",  32'(bus.oCount),  32'd0);
    chk("mid_rddata", 32'(bus.oRdData), 32'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid_unf",    32'(bus.oUnderflow), 32'(ERR_EN));
    chk("mid_rdhold", 32'(bus.oRdData),    32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_unfclr", 32'(bus.oUnderflow), 32'd0);

    // Randomized traffic. The write/read bias alternates between phases so
    // that both the full and the empty boundaries are reached.
    for (int p = 0; p < 8; p++) begin
      automatic int wrPct = (p % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 250; i++) begin
        rst = ($urandom_range(0, 299) == 0);
        step(1'($urandom_range(0, 99) < wrPct), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 99) >= wrPct),
             1'($urandom_range(0, 19) == 0));
      end
    end
    rst = 1'b0;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ftdi_byte_fifo.md
# ftdi_byte_fifo

Synchronous single-clock byte FIFO that buffers traffic between the FTDI FT2232H async bridge and the rest of the DMM logic. One instance sits upstream of the bridge's transmit side, driving its read-enable/empty/data inputs. A second instance sits downstream of its receive side, accepting its write-enable/data and returning full. Read data has one-cycle latency, matching the bridge, which samples data the cycle after it asserts read-enable.

## Interface
Parameters:
- DATA_W, 8, data width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W entries (16)
- AFULL_LEVEL, 12, oAlmostFull asserted when count >= AFULL_LEVEL
- AEMPTY_LEVEL, 2, oAlmostEmpty asserted when count <= AEMPTY_LEVEL

Ports:
- iClk  in  1  sole clock, all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iWrEn  in  1  write request; data captured on the same edge when accepted
- iWrData  in  DATA_W  write data
- oFull  out  1  no free entry
- iRdEn  in  1  read request
- oRdData  out  DATA_W  read data, valid the cycle after an accepted read, held until the next accepted read
- oEmpty  out  1  no stored entry
- oCount  out  ADDR_W+1  current occupancy, 0..2**ADDR_W
- oAlmostFull  out  1  count >= AFULL_LEVEL
- oAlmostEmpty  out  1  count <= AEMPTY_LEVEL
- iClrErr  in  1  clears sticky error flags (see Configuration)
- oOverflow  out  1  sticky: write attempted while full
- oUnderflow  out  1  sticky: read attempted while empty

## Operation
- Storage: 2**ADDR_W x DATA_W register array. Write pointer wp and read pointer rp are ADDR_W+1 bits wide; the MSB is the wrap bit.
- Empty when wp == rp. Full when the low bits are equal and the MSBs differ. Count = wp - rp, modulo 2**(ADDR_W+1).
- Write accepted = iWrEn & ~oFull: mem[wp[ADDR_W-1:0]] <= iWrData, then wp increments.
- Read accepted = iRdEn & ~oEmpty: oRdData <= mem[rp[ADDR_W-1:0]], then rp increments.
- Flags are evaluated on the registered state at the start of the cycle.
- Rejected requests have no effect on pointers, data or count.
- Simultaneous write and read:
  - When neither full nor empty, both are accepted and count is unchanged.
  - When empty, only the write is accepted; count +1, and oRdData is unchanged.
  - When full, only the read is accepted; count -1, and the write is dropped.
- Pointer wrap: low bits roll from 2**ADDR_W-1 to 0 and the MSB toggles. No entry is lost across the wrap.
- oFull, oEmpty, oCount, oAlmostFull and oAlmostEmpty are registered and reflect state after the edge.
- Memory contents are not reset.

## Timing
- Reset values: wp = rp = 0, oEmpty = 1, oFull = 0, oCount = 0, oAlmostEmpty = 1, oAlmostFull = 0, oRdData = 0, oOverflow = 0, oUnderflow = 0.
- Reset mid-operation: all stored data is discarded and outputs return to reset values on the next edge. iRst has priority over iWrEn, iRdEn and iClrErr in that cycle.
- Write-to-not-empty latency: oEmpty deasserts 1 cycle after the accepting edge.
- Read latency: oRdData updates on the edge that accepts iRdEn and is visible in the following cycle.
- Back-to-back reads every cycle give one new byte per cycle.
- Full-to-not-full: oFull deasserts the cycle after an accepted read.

## Configuration
- Macro: BYTE_FIFO_ERR_FLAGS_EN.
- Defined:
  - oOverflow sets on iWrEn & oFull; oUnderflow sets on iRdEn & oEmpty.
  - Both flags stay set until iClrErr = 1 or reset.
  - If set and clear occur in the same cycle, set wins.
- Undefined: oOverflow and oUnderflow are tied to 0, iClrErr is ignored, and no error registers are synthesized.

## Test plan
- Reset then idle: assert iRst for one edge -> oEmpty = 1, oFull = 0, oCount = 0, oRdData = 8'h00, oAlmostEmpty = 1.
- Single byte: write 8'hAA, then iRdEn next cycle -> oEmpty falls 1 cycle after the write; oRdData = 8'hAA in the cycle after the read; oEmpty = 1 again.
- Fill and overflow:
  - Write 8'h00..8'h0F (16 bytes) -> oFull = 1, oCount = 16, oAlmostFull set from count 12.
  - Extra write of 8'hFF -> dropped, oCount stays 16, oOverflow = 1 (with macro).
  - Drain -> 8'h00..8'h0F in order.
- Wrap-around: write 10 bytes, read 10, then write 12 and read 12 with values 8'h20..8'h2B -> data returned in order, oCount returns to 0, no loss across the pointer wrap.
- Simultaneous read and write:
  - At count 5, assert both for 8 cycles -> count stays 5 and output order is preserved.
  - At empty, assert both with 8'h55 -> count becomes 1 and oRdData is unchanged.
  - At full, assert both -> count becomes 15 and the write is dropped.
- Reset mid-stream: with count 7, pulse iRst -> next cycle oEmpty = 1 and oCount = 0. iRdEn is then ignored and oUnderflow sets (with macro); iClrErr clears it.
